// File: rtl/reg_arb_pkg.sv
// Shared types, default sizing and the round-robin search function for reg_write_arbiter.
package reg_arb_pkg;

  typedef enum logic {IDLE, OWN} arb_state_e;

  localparam int unsigned DEF_N_REQ    = 4;
  localparam int unsigned DEF_DW       = 8;
  localparam int unsigned DEF_MAX_HOLD = 4;
  localparam int unsigned RR_MAX_REQ   = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set, non-excluded request bit starting at ptr and wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                       input logic [7:0] exclude, input int unsigned n);
    rr_pick_t   r;
    logic [2:0] j;
    r = '0;
    for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
      j = 3'((32'(ptr) + i) % n);
      if (i < n && !r.found && req[j] && !exclude[j]) begin
        r.found = 1'b1;
        r.idx   = j;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick_logic.sv
// Combinational rotate-and-priority-encode shared by the idle grant and owner handoff paths.
module rr_pick_logic
  import reg_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  input  logic [N_REQ-1:0]         i_exclude,
  output logic                     o_found,
  output logic [$clog2(N_REQ)-1:0] o_idx
);

  localparam int unsigned OW = $clog2(N_REQ);

  rr_pick_t w_res;

  assign w_res   = rr_pick(8'(i_req), 3'(i_ptr), 8'(i_exclude), N_REQ);
  assign o_found = w_res.found;
  assign o_idx   = OW'(w_res.idx);

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin owner of a shared register's write port; ARB_HOLD_LIMIT_EN adds a MAX_HOLD
// forced-handoff limit on consecutive writes per ownership.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = DEF_N_REQ,
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DW-1:0]      wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic                     reg_en,
  output logic [DW-1:0]            reg_d
);

  localparam int unsigned OW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > RR_MAX_REQ || MAX_HOLD == 0) begin : g_bad_cfg
    $error("reg_write_arbiter: unsupported N_REQ/MAX_HOLD");
  end

  arb_state_e       r_state;
  logic [OW-1:0]    r_ptr;
  logic [OW-1:0]    r_owner;
  logic [N_REQ-1:0] r_gnt;
  logic             r_busy;

  logic             w_found;
  logic [OW-1:0]    w_idx;
  logic [N_REQ-1:0] w_exclude;
  logic             w_own_req;
  logic [DW-1:0]    w_sel;
  logic [OW-1:0]    w_next_ptr;
  logic             w_force;
  logic             w_take;
  logic             w_drop;

  // The current owner is masked out so a release or forced handoff never re-grants it.
  assign w_exclude = r_busy ? (N_REQ'(1) << r_owner) : '0;
  assign w_own_req = req[r_owner];

  rr_pick_logic #(.N_REQ(N_REQ)) u_pick (
    .i_req     (req),
    .i_ptr     (r_ptr),
    .i_exclude (w_exclude),
    .o_found   (w_found),
    .o_idx     (w_idx)
  );

  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (r_owner == OW'(i)) w_sel = wdata[i*DW +: DW];
    end
  end

  assign w_next_ptr = (w_idx == OW'(N_REQ - 1)) ? '0 : w_idx + OW'(1);

`ifdef ARB_HOLD_LIMIT_EN
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] r_hold;
  logic [HW-1:0] w_hold_inc;

  // Count includes the write happening this cycle, so the owner gets exactly MAX_HOLD writes.
  always_comb begin
    w_hold_inc = r_hold;
    if (reg_en && r_hold != HW'(MAX_HOLD)) w_hold_inc = r_hold + HW'(1);
  end

  assign w_force = (w_hold_inc == HW'(MAX_HOLD)) && w_found;
`else
  assign w_force = 1'b0;
`endif

  always_comb begin
    w_take = 1'b0;
    w_drop = 1'b0;
    case (r_state)
      IDLE: w_take = w_found;
      OWN: begin
        w_take = (!w_own_req || w_force) && w_found;
        w_drop = !w_own_req && !w_found;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      r_hold  <= '0;
`endif
    end else if (w_take) begin
      r_state <= OWN;
      r_gnt   <= N_REQ'(1) << w_idx;
      r_owner <= w_idx;
      r_ptr   <= w_next_ptr;
      r_busy  <= 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
      r_hold  <= '0;
`endif
    end else if (w_drop) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
`ifdef ARB_HOLD_LIMIT_EN
      r_hold  <= w_hold_inc;
`endif
    end
  end

  assign gnt    = r_gnt;
  assign owner  = r_owner;
  assign busy   = r_busy;
  assign reg_en = r_busy & w_own_req;
  assign reg_d  = r_busy ? w_sel : '0;

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin arbiter sharing the write port of one DW-bit D-type register among N_REQ requesters. It owns the register's load enable and data input. Each requester raises a request, receives a one-hot grant and writes one word per granted cycle. When the requester drops its request, ownership passes to the next requester in rotation. The arbiter sits directly in front of the shared register (d/q flop bank) in the datapath.

## Interface
- N_REQ, default 4: number of requesters, 2..8.
- DW, default 8: data width of the shared register.
- MAX_HOLD, default 4: maximum consecutive write cycles per ownership; used only when the hold limit is compiled in.
- clk  in  1: single clock; all state updates on the rising edge.
- rst  in  1: asynchronous, active-low reset. Asserting it (low) clears all state immediately. Release is synchronous to clk.
- req  in  N_REQ: per-requester request level; held high for as long as the requester wants to write.
- wdata  in  N_REQ*DW: requester i's data is wdata[i*DW +: DW].
- gnt  out  N_REQ: one-hot grant, registered; all zero when idle.
- owner  out  $clog2(N_REQ): index of the current owner, registered; valid only while busy.
- busy  out  1: high in state OWN.
- reg_en  out  1: load enable to the shared register. Combinational: reg_en = busy & req[owner].
- reg_d  out  DW: data to the shared register; equals wdata slice [owner]; 0 when not busy.

## Operation
- States:
  - IDLE: no owner.
  - OWN: gnt[owner]=1.
- Round-robin pointer ptr:
  - Search order is ptr, ptr+1, … modulo N_REQ.
  - After each grant, ptr = winner+1, wrapping from N_REQ-1 to 0.
- IDLE:
  - Any req bit high: the first set bit in search order wins. Next state OWN; gnt and owner are loaded with the winner.
  - No req bit high: stay in IDLE.
- OWN, req[owner]=1: stay; the grant is held; one write per cycle (reg_en=1).
- OWN, req[owner]=0 with another req high: direct handoff in the same edge to the next winner in search order. No idle cycle is inserted. The released owner is excluded from the search.
- OWN, req[owner]=0 with no other req: next state IDLE; gnt cleared.
- A requester that drops req and reraises it while still granted keeps ownership. Release is evaluated only on the edge that samples req[owner]=0.
- Simultaneous requests in IDLE: resolved purely by ptr. Example: ptr=0 with req=4'b1010 grants requester 1.
- reg_en never asserts for a non-owner; at most one gnt bit is ever high.
- Reset values:
  - state=IDLE, ptr=0, owner=0, gnt=0, busy=0, hold count=0.
  - reg_en=0 and reg_d=0, as a consequence of busy=0.
- Reset mid-ownership: gnt drops immediately (asynchronously). Any write in progress is abandoned. The register itself is not touched by the arbiter.

## Timing
- Grant latency: req sampled high at edge k → gnt visible after edge k. The first write is captured by the register at edge k+1.
- Handoff: the edge that samples the owner's req low also loads the new gnt. The new owner's first write is captured one edge later.
- Maximum throughput: one register write per cycle while any requester is granted and requesting.
- The combinational path req/wdata → reg_en/reg_d is a single mux level; no other combinational outputs.

## Configuration
- Macro ARB_HOLD_LIMIT_EN.
- Defined:
  - A hold counter counts write cycles (reg_en=1) of the current owner.
  - When the count reaches MAX_HOLD and any other req is high, ownership is forcibly handed off on that edge.
  - If no other requester is waiting, the owner keeps the grant and the counter saturates at MAX_HOLD.
  - The counter clears on every new grant.
- Undefined: no counter; the owner holds the grant until it drops req. MAX_HOLD is ignored.

## Structure
- Shared package reg_arb_pkg holds:
  - the state enum (IDLE, OWN);
  - the default constants for N_REQ, DW and MAX_HOLD;
  - the function rr_pick(req, ptr, exclude) returning the index and a found flag.
- One sub-module, rr_pick_logic: the combinational rotate-and-priority-encode used for both IDLE grant and handoff. The top instantiates it once.

## Test plan
- Reset: rst low with req=4'b1111 → gnt=0, busy=0, reg_en=0. Release rst with req=4'b0100 → after the next edge gnt=4'b0100, owner=2. The next edge writes wdata[2] into the register; q matches.
- Simultaneous requests: after reset, req=4'b1010 → grant 1 first. Drop req[1] → handoff directly to 3 with no idle cycle. Drop req[3] → IDLE.
- Wrap-around: with ptr=3 after a grant to 2, req=4'b0011 → grant 0, then ptr=1.
- Write count: owner 0 holds req for 3 cycles with wdata 8'hA1, 8'hA2, 8'hA3 → exactly 3 reg_en pulses; final q=8'hA3; no write by any non-owner.
- ARB_HOLD_LIMIT_EN, MAX_HOLD=4: req=4'b0011 held continuously → gnt alternates 0,0,0,0,1,1,1,1,0… Repeat with only req[0] high → grant held indefinitely.
- Mid-operation reset: assert rst during a write burst → gnt goes 0 before the next edge. After release, the arbiter is IDLE with ptr=0.
